// File: rtl/cache_pkg.sv
// cache_types: shared types for the direct-mapped L1 cache.
// Address split, line/tag types, FSM states, byte merge.
package cache_types;
  localparam int IDX_BITS = 3;
  localparam int OFF_BITS = 4;
  localparam int NUM_SETS = 2 ** IDX_BITS;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [2:0]   lc3b_c_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } cache_state_e;

  // Merge the enabled byte lanes of wdata into word w of a line.
  function automatic lc3b_c_line merge_word(
    input lc3b_c_line  line,
    input lc3b_c_word  w,
    input logic [15:0] wdata,
    input logic [1:0]  be
  );
    lc3b_c_line r;
    r = line;
    if (be[0]) r[{w, 4'd0} +: 8] = wdata[7:0];
    if (be[1]) r[{w, 4'd8} +: 8] = wdata[15:8];
    return r;
  endfunction
endpackage

// File: rtl/cache_control.sv
// cache_control: IDLE / WRITEBACK / ALLOCATE miss FSM.
// pmem strobes are registered; mem_resp is a same-cycle hit.
module cache_control
  import cache_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic dirty,
  input  logic mem_read,
  input  logic mem_write,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_line,
  output logic load_word,
  output logic set_dirty,
  output logic clr_dirty,
  output logic pmemaddr_sel
);
  cache_state_e state_q, state_d;
  logic pmem_read_q, pmem_read_d;
  logic pmem_write_q, pmem_write_d;
  logic req;
  logic idle;

  assign req  = mem_read | mem_write;
  assign idle = (state_q == S_IDLE);

  // Next state and next pmem strobes.
  always_comb begin
    state_d      = state_q;
    pmem_read_d  = 1'b0;
    pmem_write_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          if (dirty) begin
            state_d      = S_WRITEBACK;
            pmem_write_d = 1'b1;
          end else begin
            state_d     = S_ALLOCATE;
            pmem_read_d = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        if (pmem_resp) begin
          state_d     = S_ALLOCATE;
          pmem_read_d = 1'b1;
        end else begin
          pmem_write_d = 1'b1;
        end
      end
      S_ALLOCATE: begin
        if (pmem_resp) state_d = S_IDLE;
        else pmem_read_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered pmem strobes; reset aborts any miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign mem_resp     = idle & req & hit;
  assign load_word    = idle & hit & mem_write;
  assign set_dirty    = load_word;
  assign load_line    = (state_q == S_ALLOCATE) & pmem_resp;
  assign clr_dirty    = load_line;
  assign pmemaddr_sel = (state_q == S_WRITEBACK);
endmodule

// File: rtl/cache.sv
// cache: direct-mapped write-back write-allocate L1.
// Holds tag/line arrays, hit compare, word merge and muxes.
module cache
  import cache_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  lc3b_c_tag   addr_tag;
  lc3b_c_index idx;
  lc3b_c_word  word;
  logic        unused_bit0;

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  lc3b_c_tag  tag_q  [NUM_SETS];
  lc3b_c_line line_q [NUM_SETS];
  lc3b_c_line line_d;

  logic hit;
  logic load_line, load_word;
  logic set_dirty, clr_dirty;
  logic pmemaddr_sel;

  assign addr_tag    = mem_address[15:7];
  assign idx         = mem_address[6:4];
  assign word        = mem_address[3:1];
  assign unused_bit0 = mem_address[0];

  assign hit = valid_q[idx] && (tag_q[idx] == addr_tag);

  cache_control u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .hit          (hit),
    .dirty        (dirty_q[idx]),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pmem_resp    (pmem_resp),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .load_line    (load_line),
    .load_word    (load_word),
    .set_dirty    (set_dirty),
    .clr_dirty    (clr_dirty),
    .pmemaddr_sel (pmemaddr_sel)
  );

  // Next valid/dirty bits and the line to store at idx.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (load_line) valid_d[idx] = 1'b1;
    if (clr_dirty) dirty_d[idx] = 1'b0;
    if (set_dirty) dirty_d[idx] = 1'b1;
    if (load_line) line_d = pmem_rdata;
    else line_d = merge_word(line_q[idx], word,
                             mem_wdata, mem_byte_enable);
  end

  // Valid/dirty state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and line storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_line || load_word) line_q[idx] <= line_d;
    if (load_line) tag_q[idx] <= addr_tag;
  end

  assign mem_rdata    = line_q[idx][{word, 4'd0} +: 16];
  assign pmem_wdata   = line_q[idx];
  assign pmem_address = pmemaddr_sel
    ? {tag_q[idx], idx, {OFF_BITS{1'b0}}}
    : {addr_tag,   idx, {OFF_BITS{1'b0}}};
endmodule

// File: tb/tb_cache.sv
// tb_cache: directed bench for the L1 cache with a
// line-wide physical memory model of fixed latency.
module tb_cache;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int errors = 0;
  int checks = 0;

  logic [127:0] store [int];
  int           fills = 0;
  int           wbs = 0;
  logic [15:0]  last_fill_addr = '0;
  logic [15:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;
  bit           both_seen = 1'b0;

  cache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] init_line(input int n);
    logic [127:0] l;
    for (int i = 0; i < 8; i++)
      l[i*16 +: 16] = 16'(32'h1110 + n * 16 + i);
    return l;
  endfunction

  function automatic logic [127:0] get_line(input int n);
    if (store.exists(n)) return store[n];
    return init_line(n);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Physical memory: responds LAT cycles into a request,
  // and forgets a request that drops early.
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) both_seen = 1'b1;
      assert (!(mem_read && mem_write)) else begin
        errors++;
        $error("FAIL rw_both: read and write both high");
      end
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
      if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == LAT) begin
          pmem_resp = 1'b1;
          if (pmem_write) begin
            store[int'(pmem_address[15:4])] = pmem_wdata;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            wbs++;
          end else begin
            pmem_rdata = get_line(int'(pmem_address[15:4]));
            last_fill_addr = pmem_address;
            fills++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cpu(input bit wr,
                     input logic [15:0] a,
                     input logic [1:0] be,
                     input logic [15:0] wd,
                     output logic [15:0] rd,
                     output int cyc);
    bit ok;
    ok  = 1'b0;
    rd  = 'x;
    cyc = 0;
    @(negedge clk);
    mem_address     = a;
    mem_read        = !wr;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (mem_resp === 1'b1) begin
        rd = mem_rdata;
        ok = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    check("resp_seen", {31'b0, ok}, 32'd1);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_pmem_read(input bit level,
                                input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pmem_read === level) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    logic [15:0] rd;
    int          cyc;
    int          f0, w0;

    rst = 1'b1;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b11;
    mem_wdata = '0;

    repeat (3) @(negedge clk);
    mem_read = 1'b1;
    #1;
    check("rst_resp", {31'b0, mem_resp}, 32'd0);
    check("rst_pread", {31'b0, pmem_read}, 32'd0);
    check("rst_pwrite", {31'b0, pmem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_resp", {31'b0, mem_resp}, 32'd0);
    check("post_rst_pread", {31'b0, pmem_read}, 32'd0);
    mem_read = 1'b0;

    cpu(0, 16'h0000, 2'b11, 16'h0, rd, cyc);
    check("miss0_data", 32'(rd), 32'h1110);
    check("miss0_lat", cyc, LAT + 1);
    check("miss0_addr", 32'(last_fill_addr), 32'h0000);
    check("miss0_fills", fills, 1);

    cpu(0, 16'h0006, 2'b11, 16'h0, rd, cyc);
    check("hit6_data", 32'(rd), 32'h1113);
    check("hit6_lat", cyc, 0);
    check("hit6_fills", fills, 1);

    cpu(1, 16'h0002, 2'b01, 16'hBEEF, rd, cyc);
    check("wr_lo_lat", cyc, 0);
    cpu(1, 16'h0004, 2'b10, 16'hBEEF, rd, cyc);
    cpu(1, 16'h0008, 2'b11, 16'hCAFE, rd, cyc);
    cpu(0, 16'h0002, 2'b00, 16'h0, rd, cyc);
    check("rd_lo_byte", 32'(rd), 32'h11EF);
    cpu(0, 16'h0005, 2'b11, 16'h0, rd, cyc);
    check("rd_hi_byte", 32'(rd), 32'hBE12);
    cpu(0, 16'h0008, 2'b11, 16'h0, rd, cyc);
    check("rd_word", 32'(rd), 32'hCAFE);
    check("wr_fills", fills, 1);

    w0 = wbs;
    cpu(0, 16'h0080, 2'b11, 16'h0, rd, cyc);
    check("dirty_lat", cyc, 2 * LAT + 1);
    check("wb_count", wbs, w0 + 1);
    check("wb_addr", 32'(last_wb_addr), 32'h0000);
    check("wb_w1", 32'(last_wb_data[31:16]), 32'h11EF);
    check("wb_w2", 32'(last_wb_data[47:32]), 32'hBE12);
    check("wb_w4", 32'(last_wb_data[79:64]), 32'hCAFE);
    check("fill80_addr", 32'(last_fill_addr), 32'h0080);
    check("fill80_data", 32'(rd), 32'h1190);

    w0 = wbs;
    cpu(0, 16'h0000, 2'b11, 16'h0, rd, cyc);
    check("clean_lat", cyc, LAT + 1);
    check("clean_nowb", wbs, w0);
    cpu(0, 16'h0002, 2'b11, 16'h0, rd, cyc);
    check("wb_persist", 32'(rd), 32'h11EF);

    for (int k = 1; k < 8; k++)
      cpu(0, 16'(k * 16), 2'b11, 16'h0, rd, cyc);
    f0 = fills;
    for (int k = 0; k < 8; k++) begin
      cpu(0, 16'(k * 16 + 2), 2'b11, 16'h0, rd, cyc);
      check("set_hit_lat", cyc, 0);
      check("set_hit_data", 32'(rd),
            (k == 0) ? 32'h11EF : 32'h1110 + k * 16 + 1);
    end
    check("set_no_fill", fills, f0);

    @(negedge clk);
    mem_address = 16'h0180;
    mem_read = 1'b1;
    wait_pmem_read(1'b1, "drop_start");
    mem_read = 1'b0;
    wait_pmem_read(1'b0, "drop_done");
    cpu(0, 16'h0182, 2'b11, 16'h0, rd, cyc);
    check("drop_hit_lat", cyc, 0);
    check("drop_hit_data", 32'(rd), 32'h1291);

    f0 = fills;
    @(negedge clk);
    mem_address = 16'h0100;
    mem_read = 1'b1;
    wait_pmem_read(1'b1, "abort_start");
    #2;
    rst = 1'b1;
    mem_read = 1'b0;
    #1;
    check("abort_pread", {31'b0, pmem_read}, 32'd0);
    check("abort_pwrite", {31'b0, pmem_write}, 32'd0);
    check("abort_nofill", fills, f0);
    @(negedge clk);
    rst = 1'b0;
    cpu(0, 16'h0100, 2'b11, 16'h0, rd, cyc);
    check("abort_remiss", cyc, LAT + 1);
    check("abort_data", 32'(rd), 32'h1210);

    check("rw_exclusive", {31'b0, both_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end
endmodule
